// File: rtl/gamma_pkg.sv
// Shared defaults, knot type and identity-curve helper for the gamma PWL engine.
package gamma_pkg;

  localparam int NUM_CH_DEF = 3;
  localparam int DATA_W_DEF = 12;
  localparam int OUT_W_DEF  = 12;
  localparam int LUT_AW_DEF = 6;

  typedef logic [OUT_W_DEF-1:0] knot_t;

  // Knot i of the straight-line curve; the last knot saturates at full scale.
  function automatic int identity_knot(input int i, input int out_w, input int lut_aw);
    int k;
    k = i << (out_w - lut_aw);
    if (k > (1 << out_w) - 1) k = (1 << out_w) - 1;
    return k;
  endfunction

endpackage

// File: rtl/gamma_pwl_interp.sv
// One channel of knot-pair registering (S1) and linear interpolation (S2).
// Latency: 2 load strobes from the S0 fields to y_o.
// Backpressure: stages load only on ld1_i/ld2_i, so everything holds while stalled.
module gamma_pwl_interp
  import gamma_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int LUT_AW = LUT_AW_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ld1_i,
  input  logic              ld2_i,
  input  logic              byp_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [OUT_W-1:0]  k0_i,
  input  logic [OUT_W-1:0]  k1_i,
  output logic [OUT_W-1:0]  y_o
);

  localparam int FRAC_W = DATA_W - LUT_AW;
  localparam int PW     = OUT_W + FRAC_W + 2;

  logic [DATA_W-1:0]     s1_x;
  logic [OUT_W-1:0]      s1_k0;
  logic [OUT_W-1:0]      s1_k1;
  logic                  s1_byp;
  logic signed [OUT_W:0] diff;
  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  step;
  logic [OUT_W-1:0]      y_nxt;
  logic                  unused_step_hi;

  // Floor shift keeps negative slopes rounding toward K[idx+1]; the sum always fits OUT_W.
  always_comb begin
    diff  = $signed({1'b0, s1_k1}) - $signed({1'b0, s1_k0});
    prod  = PW'(diff) * PW'($signed({1'b0, s1_x[FRAC_W-1:0]}));
    step  = prod >>> FRAC_W;
    y_nxt = s1_byp ? s1_x : s1_k0 + step[OUT_W-1:0];
  end

  assign unused_step_hi = ^step[PW-1:OUT_W];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_x   <= '0;
      s1_k0  <= '0;
      s1_k1  <= '0;
      s1_byp <= 1'b0;
      y_o    <= '0;
    end else begin
      if (ld1_i) begin
        s1_x   <= x_i;
        s1_k0  <= k0_i;
        s1_k1  <= k1_i;
        s1_byp <= byp_i;
      end
      if (ld2_i) y_o <= y_nxt;
    end
  end

endmodule

// File: rtl/gamma_pwl_engine.sv
// Per-channel piecewise-linear gamma with double-buffered knot banks swapped at frame start.
// Latency: 3 cycles from accepted beat to out_valid_o.
// Backpressure: one global enable stalls all stages; pix_ready_o drops while the output is held.
module gamma_pwl_engine
  import gamma_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int LUT_AW = LUT_AW_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      cfg_bypass_i,
  input  logic                      cfg_wr_en_i,
  input  logic [$clog2(NUM_CH)-1:0] cfg_wr_ch_i,
  input  logic [LUT_AW:0]           cfg_wr_addr_i,
  input  logic [OUT_W-1:0]          cfg_wr_data_i,
  input  logic                      cfg_swap_req_i,
  output logic                      cfg_busy_o,
  output logic                      cfg_swap_done_o,
  input  logic [NUM_CH*DATA_W-1:0]  pix_data_i,
  input  logic                      pix_sof_i,
  input  logic                      pix_valid_i,
  output logic                      pix_ready_o,
  output logic [NUM_CH*OUT_W-1:0]   out_data_o,
  output logic                      out_sof_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i
);

  localparam int FRAC_W  = DATA_W - LUT_AW;
  localparam int ENTRIES = (1 << LUT_AW) + 1;
  localparam int IW      = LUT_AW + 1;

  logic [OUT_W-1:0] bank_a [NUM_CH][ENTRIES];
  logic [OUT_W-1:0] bank_b [NUM_CH][ENTRIES];

  logic                     act_sel;
  logic                     swap_pending;
  logic                     swap_done;
  logic                     en;
  logic                     accept;
  logic                     swap_evt;
  logic                     wr_ok;
  logic                     s0_vld, s0_sof, s0_byp, s0_sel;
  logic [NUM_CH*DATA_W-1:0] s0_x;
  logic                     s1_vld, s1_sof;
  logic                     out_vld_q, out_sof_q;

  assign en              = out_ready_i | ~out_vld_q;
  assign pix_ready_o     = en;
  assign accept          = pix_valid_i & en;
  assign swap_evt        = accept & pix_sof_i & swap_pending;
  assign wr_ok           = cfg_wr_en_i & ~swap_pending & (int'(cfg_wr_ch_i) < NUM_CH)
                         & (int'(cfg_wr_addr_i) < ENTRIES);
  assign cfg_busy_o      = swap_pending;
  assign cfg_swap_done_o = swap_done;
  assign out_valid_o     = out_vld_q;
  assign out_sof_o       = out_sof_q;

  // act_sel=0 means bank A is active; writes always land in the other bank.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      act_sel      <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      swap_done <= swap_evt;
      if (swap_evt) begin
        act_sel      <= ~act_sel;
        swap_pending <= cfg_swap_req_i;
      end else if (cfg_swap_req_i) begin
        swap_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int e = 0; e < ENTRIES; e++) begin
          bank_a[c][e] <= OUT_W'(identity_knot(e, OUT_W, LUT_AW));
          bank_b[c][e] <= OUT_W'(identity_knot(e, OUT_W, LUT_AW));
        end
      end
    end else if (wr_ok) begin
      if (act_sel) bank_a[cfg_wr_ch_i][cfg_wr_addr_i] <= cfg_wr_data_i;
      else         bank_b[cfg_wr_ch_i][cfg_wr_addr_i] <= cfg_wr_data_i;
    end
  end

  // The swapping beat already picks the new bank, so beats behind it never see the old one.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s0_vld    <= 1'b0;
      s0_sof    <= 1'b0;
      s0_byp    <= 1'b0;
      s0_sel    <= 1'b0;
      s0_x      <= '0;
      s1_vld    <= 1'b0;
      s1_sof    <= 1'b0;
      out_vld_q <= 1'b0;
      out_sof_q <= 1'b0;
    end else if (en) begin
      s0_vld <= accept;
      s0_sof <= accept & pix_sof_i;
      if (accept) begin
        s0_x   <= pix_data_i;
        s0_byp <= cfg_bypass_i;
        s0_sel <= act_sel ^ swap_evt;
      end
      s1_vld    <= s0_vld;
      s1_sof    <= s0_sof;
      out_vld_q <= s1_vld;
      out_sof_q <= s1_sof;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [IW-1:0]    idx_lo;
    logic [IW-1:0]    idx_hi;
    logic [OUT_W-1:0] k0;
    logic [OUT_W-1:0] k1;

    assign idx_lo = {1'b0, s0_x[g*DATA_W+FRAC_W +: LUT_AW]};
    assign idx_hi = idx_lo + IW'(1);
    assign k0     = s0_sel ? bank_b[g][idx_lo] : bank_a[g][idx_lo];
    assign k1     = s0_sel ? bank_b[g][idx_hi] : bank_a[g][idx_hi];

    gamma_pwl_interp #(
      .DATA_W (DATA_W),
      .OUT_W  (OUT_W),
      .LUT_AW (LUT_AW)
    ) u_interp (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .ld1_i   (en & s0_vld),
      .ld2_i   (en & s1_vld),
      .byp_i   (s0_byp),
      .x_i     (s0_x[g*DATA_W +: DATA_W]),
      .k0_i    (k0),
      .k1_i    (k1),
      .y_o     (out_data_o[g*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_gamma_pwl_engine.sv
// Directed bench for gamma_pwl_engine with a queue-based scoreboard and decoupled monitor.
module tb_gamma_pwl_engine;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        cfg_bypass_i = 1'b0;
  logic        cfg_wr_en_i = 1'b0;
  logic [1:0]  cfg_wr_ch_i = '0;
  logic [6:0]  cfg_wr_addr_i = '0;
  logic [11:0] cfg_wr_data_i = '0;
  logic        cfg_swap_req_i = 1'b0;
  logic        cfg_busy_o;
  logic        cfg_swap_done_o;
  logic [35:0] pix_data_i = '0;
  logic        pix_sof_i = 1'b0;
  logic        pix_valid_i = 1'b0;
  logic        pix_ready_o;
  logic [35:0] out_data_o;
  logic        out_sof_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;

  int          total = 0;
  int          bad = 0;
  int          swap_cnt = 0;
  int          out_n = 0;
  logic [36:0] sb[$];
  logic [36:0] sb_e;

  always #5 clk_i = ~clk_i;

  gamma_pwl_engine dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .cfg_bypass_i    (cfg_bypass_i),
    .cfg_wr_en_i     (cfg_wr_en_i),
    .cfg_wr_ch_i     (cfg_wr_ch_i),
    .cfg_wr_addr_i   (cfg_wr_addr_i),
    .cfg_wr_data_i   (cfg_wr_data_i),
    .cfg_swap_req_i  (cfg_swap_req_i),
    .cfg_busy_o      (cfg_busy_o),
    .cfg_swap_done_o (cfg_swap_done_o),
    .pix_data_i      (pix_data_i),
    .pix_sof_i       (pix_sof_i),
    .pix_valid_i     (pix_valid_i),
    .pix_ready_o     (pix_ready_o),
    .out_data_o      (out_data_o),
    .out_sof_o       (out_sof_o),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for the DUT", nm);
  endtask

  function automatic logic [35:0] pk(input logic [11:0] c2, input logic [11:0] c1, input logic [11:0] c0);
    return {c2, c1, c0};
  endfunction

  // Monitor: pops one expectation per transferred output beat.
  always @(negedge clk_i) begin
    if (rst_n_i && out_valid_o && out_ready_i) begin
      out_n++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got beat %h, want no beat", out_data_o);
      end else begin
        sb_e = sb.pop_front();
        chk($sformatf("sb_beat%0d", out_n), {27'd0, out_sof_o, out_data_o}, {27'd0, sb_e});
      end
    end
    if (cfg_swap_done_o) swap_cnt++;
  end

  task automatic send(input logic [35:0] d, input logic sof, input logic byp, input logic [35:0] e);
    int n;
    n = 0;
    pix_data_i   = d;
    pix_sof_i    = sof;
    cfg_bypass_i = byp;
    pix_valid_i  = 1'b1;
    @(negedge clk_i);
    while (!pix_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!pix_ready_o) begin
      timeout("accept");
      pix_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    sb.push_back({sof, e});
    #1;
    pix_valid_i  = 1'b0;
    pix_sof_i    = 1'b0;
    cfg_bypass_i = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [6:0] addr, input logic [11:0] val);
    cfg_wr_ch_i   = ch;
    cfg_wr_addr_i = addr;
    cfg_wr_data_i = val;
    cfg_wr_en_i   = 1'b1;
    @(posedge clk_i);
    #1 cfg_wr_en_i = 1'b0;
  endtask

  task automatic swap_req();
    cfg_swap_req_i = 1'b1;
    @(posedge clk_i);
    #1 cfg_swap_req_i = 1'b0;
  endtask

  task automatic lat_chk(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!out_valid_o && n < 10);
    chk(nm, 64'(n), 64'd3);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (sb.size() != 0) timeout("drain");
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  initial begin
    int c;
    logic [35:0] snap;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_out_data", 64'(out_data_o), 64'd0);
    chk("rst_out_sof", 64'(out_sof_o), 64'd0);
    chk("rst_busy", 64'(cfg_busy_o), 64'd0);
    chk("rst_swap_done", 64'(cfg_swap_done_o), 64'd0);
    chk("rst_pix_ready", 64'(pix_ready_o), 64'd1);
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;

    // Identity curve, including the saturated top segment.
    send(pk(12'hFFF, 12'h123, 12'h800), 1'b0, 1'b0, pk(12'hFFE, 12'h123, 12'h800));
    lat_chk("lat_interp");
    drain();

    // Positive slope after a swap.
    cfg_write(2'd0, 7'd10, 12'd100);
    cfg_write(2'd0, 7'd11, 12'd200);
    swap_req();
    chk("busy_after_req", 64'(cfg_busy_o), 64'd1);
    send(pk(12'h000, 12'h123, 12'h2A0), 1'b1, 1'b0, pk(12'h000, 12'h123, 12'd150));
    @(negedge clk_i);
    chk("swap_done_pulse", 64'(cfg_swap_done_o), 64'd1);
    chk("busy_cleared", 64'(cfg_busy_o), 64'd0);
    @(negedge clk_i);
    chk("swap_done_low", 64'(cfg_swap_done_o), 64'd0);
    drain();

    // Negative slope with floor shift.
    cfg_write(2'd0, 7'd10, 12'd100);
    cfg_write(2'd0, 7'd11, 12'd40);
    swap_req();
    send(pk(12'h040, 12'h7FF, 12'h290), 1'b1, 1'b0, pk(12'h040, 12'h7FF, 12'd85));
    drain();

    // Pending swap waits for sof; a write while busy is dropped.
    c = swap_cnt;
    swap_req();
    cfg_write(2'd0, 7'd10, 12'd999);
    send(pk(12'h000, 12'h000, 12'h2A0), 1'b0, 1'b0, pk(12'h000, 12'h000, 12'd70));
    send(pk(12'h000, 12'h000, 12'h2A0), 1'b0, 1'b0, pk(12'h000, 12'h000, 12'd70));
    chk("busy_hold_nonsof", 64'(cfg_busy_o), 64'd1);
    chk("no_swap_nonsof", 64'(swap_cnt), 64'(c));
    send(pk(12'h000, 12'h000, 12'h2A0), 1'b1, 1'b0, pk(12'h000, 12'h000, 12'd150));
    drain();
    chk("swap_once", 64'(swap_cnt), 64'(c + 1));
    chk("busy_after_sof", 64'(cfg_busy_o), 64'd0);

    // Output stall with four beats offered.
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          send(pk(12'hF00 - 12'(i * 16), 12'h555 + 12'(i), 12'h100 + 12'(i * 'h111)), 1'b0, 1'b0,
               pk(12'hF00 - 12'(i * 16), 12'h555 + 12'(i), 12'h100 + 12'(i * 'h111)));
        end
      end
      begin
        int n;
        n = 0;
        out_ready_i = 1'b0;
        @(negedge clk_i);
        while (!out_valid_o && n < 20) begin
          @(negedge clk_i);
          n++;
        end
        if (!out_valid_o) timeout("stall_valid");
        snap = out_data_o;
        repeat (5) begin
          @(negedge clk_i);
          chk("stall_pix_ready", 64'(pix_ready_o), 64'd0);
          chk("stall_hold", 64'(out_data_o), 64'(snap));
        end
        @(posedge clk_i);
        #1 out_ready_i = 1'b1;
      end
    join
    drain();

    // Bypass and the extreme code.
    send(pk(12'hABC, 12'hABC, 12'hABC), 1'b0, 1'b1, pk(12'hABC, 12'hABC, 12'hABC));
    lat_chk("lat_bypass");
    drain();
    send(pk(12'hFFF, 12'hFFF, 12'hFFF), 1'b0, 1'b1, pk(12'hFFF, 12'hFFF, 12'hFFF));
    send(pk(12'hFFF, 12'h000, 12'hFFF), 1'b0, 1'b0, pk(12'hFFE, 12'h000, 12'hFFE));
    drain();

    // A request coinciding with the swapping beat re-arms for the next frame.
    c = swap_cnt;
    swap_req();
    cfg_swap_req_i = 1'b1;
    send(pk(12'h000, 12'h000, 12'h290), 1'b1, 1'b0, pk(12'h000, 12'h000, 12'd85));
    cfg_swap_req_i = 1'b0;
    chk("busy_rearmed", 64'(cfg_busy_o), 64'd1);
    send(pk(12'h000, 12'h000, 12'h2A0), 1'b1, 1'b0, pk(12'h000, 12'h000, 12'd150));
    drain();
    chk("swap_twice", 64'(swap_cnt), 64'(c + 2));
    chk("busy_done_rearm", 64'(cfg_busy_o), 64'd0);

    // Reset mid-frame drops in-flight beats, the pending swap and the programmed knots.
    swap_req();
    send(pk(12'h001, 12'h002, 12'h003), 1'b1, 1'b0, pk(12'h001, 12'h002, 12'h003));
    send(pk(12'h004, 12'h005, 12'h006), 1'b0, 1'b0, pk(12'h004, 12'h005, 12'h006));
    send(pk(12'h007, 12'h008, 12'h009), 1'b0, 1'b0, pk(12'h007, 12'h008, 12'h009));
    #2 rst_n_i = 1'b0;
    sb.delete();
    #1;
    chk("midrst_valid", 64'(out_valid_o), 64'd0);
    chk("midrst_data", 64'(out_data_o), 64'd0);
    chk("midrst_busy", 64'(cfg_busy_o), 64'd0);
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    c = swap_cnt;
    send(pk(12'h123, 12'h290, 12'h2A0), 1'b1, 1'b0, pk(12'h123, 12'h290, 12'h2A0));
    drain();
    chk("no_swap_after_rst", 64'(swap_cnt), 64'(c));
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
